// File: rtl/display_pkg.sv
// Shared display geometry and arbiter state encoding for the hex display slice.
package display_pkg;

  localparam int DIGIT_W    = 4;
  localparam int NUM_DIGITS = 8;
  localparam int DISPLAY_W  = DIGIT_W * NUM_DIGITS;

  typedef enum logic {
    IDLE,
    OWNED
  } arb_state_t;

endpackage

// File: rtl/rr_priority_pick.sv
// Combinational round-robin picker: first requester at or after start (mod N),
// skipping any requester flagged in exclude.
module rr_priority_pick #(
  parameter int N  = 4,
  parameter int IW = (N > 1) ? $clog2(N) : 1
) (
  input  logic [N-1:0]  req,
  input  logic [IW-1:0] start,
  input  logic [N-1:0]  exclude,
  output logic          found,
  output logic [IW-1:0] idx
);

  logic [N-1:0]   eligible;
  logic [2*N-1:0] doubled;
  logic [N-1:0]   rotated;
  logic [IW-1:0]  offset;
  logic [IW:0]    sum;

  // Rotating a doubled copy turns the wrap-around scan into a plain
  // lowest-set-bit search starting at bit 0.
  assign eligible = req & ~exclude;
  assign doubled  = {eligible, eligible} >> start;
  assign rotated  = doubled[N-1:0];
  assign found    = |rotated;

  always_comb begin
    // NOTE: every variable written here gets a default first, so no path can
    // leave it unassigned and infer a latch.
    offset = '0;
    for (int k = N - 1; k >= 0; k--) begin
      if (rotated[k]) offset = IW'(k);
    end
  end

  always_comb begin
    sum = {1'b0, start} + {1'b0, offset};
    if (sum >= (IW + 1)'(N)) sum = sum - (IW + 1)'(N);
  end

  assign idx = sum[IW-1:0];

endmodule

// File: rtl/hex_display_arbiter.sv
// Round-robin owner of the shared 8-digit hex display with a minimum dwell time.
// Optional HEX_ARB_SOURCE_TAG_EN replaces the top digit with the owner index.
module hex_display_arbiter
  import display_pkg::*;
#(
  parameter int                   NUM_REQ      = 4,
  parameter int                   DWELL_CYCLES = 100_000_000,
  parameter logic [DISPLAY_W-1:0] IDLE_PATTERN = 32'h0000_0000
) (
  input  logic                           clk_in,
  input  logic                           rst_in,
  input  logic [NUM_REQ-1:0]             req_in,
  input  logic [NUM_REQ*DISPLAY_W-1:0]   data_in,
  output logic [NUM_REQ-1:0]             grant_out,
  output logic [$clog2(NUM_REQ)-1:0]     owner_out,
  output logic                           busy_out,
  output logic [DISPLAY_W-1:0]           data_out
);

  localparam int OW = $clog2(NUM_REQ);
  localparam int CW = (DWELL_CYCLES > 1) ? $clog2(DWELL_CYCLES + 1) : 1;
  localparam logic [CW-1:0] DWELL_LOAD = CW'(DWELL_CYCLES - 1);

  arb_state_t             state_q, state_d;
  logic [OW-1:0]          owner_q, owner_d;
  logic [CW-1:0]          count_q, count_d;
  logic [NUM_REQ-1:0]     grant_q, grant_d;
  logic                   busy_q, busy_d;
  logic [DISPLAY_W-1:0]   data_q, data_d;

  logic [DISPLAY_W-1:0]   words [NUM_REQ];
  logic                   owner_req;
  logic [OW-1:0]          scan_start;
  logic [NUM_REQ-1:0]     exclude;
  logic                   pick_found;
  logic [OW-1:0]          pick_idx;
  logic [DISPLAY_W-1:0]   pick_word, own_word;

  for (genvar i = 0; i < NUM_REQ; i++) begin : g_words
    assign words[i] = data_in[i*DISPLAY_W +: DISPLAY_W];
  end

  assign owner_req  = req_in[owner_q];
  assign scan_start = (owner_q == OW'(NUM_REQ - 1)) ? '0 : owner_q + 1'b1;
  // Only a still-requesting owner is masked out; that is the preempt case.
  assign exclude    = (state_q == OWNED && owner_req) ? (NUM_REQ'(1) << owner_q) : '0;

  rr_priority_pick #(.N(NUM_REQ), .IW(OW)) u_pick (
    .req     (req_in),
    .start   (scan_start),
    .exclude (exclude),
    .found   (pick_found),
    .idx     (pick_idx)
  );

`ifdef HEX_ARB_SOURCE_TAG_EN
  assign pick_word = {DIGIT_W'(pick_idx), words[pick_idx][DISPLAY_W-DIGIT_W-1:0]};
  assign own_word  = {DIGIT_W'(owner_q),  words[owner_q][DISPLAY_W-DIGIT_W-1:0]};
`else
  assign pick_word = words[pick_idx];
  assign own_word  = words[owner_q];
`endif

  always_comb begin
    state_d = state_q;
    owner_d = owner_q;
    count_d = count_q;
    grant_d = grant_q;
    busy_d  = busy_q;
    data_d  = data_q;

    case (state_q)
      IDLE: begin
        if (pick_found) begin
          state_d = OWNED;
          owner_d = pick_idx;
          count_d = DWELL_LOAD;
          grant_d = NUM_REQ'(1) << pick_idx;
          busy_d  = 1'b1;
          data_d  = pick_word;
        end
      end
      OWNED: begin
        // Release outranks expiry, so a drop on the expiry edge is a handover.
        if (!owner_req || (count_q == '0 && pick_found)) begin
          if (pick_found) begin
            owner_d = pick_idx;
            count_d = DWELL_LOAD;
            grant_d = NUM_REQ'(1) << pick_idx;
            data_d  = pick_word;
          end else begin
            state_d = IDLE;
            count_d = '0;
            grant_d = '0;
            busy_d  = 1'b0;
            data_d  = IDLE_PATTERN;
          end
        end else begin
          if (count_q != '0) count_d = count_q - 1'b1;
          data_d = own_word;
        end
      end
      default: begin
        state_d = IDLE;
        grant_d = '0;
        busy_d  = 1'b0;
        data_d  = IDLE_PATTERN;
      end
    endcase
  end

  // NOTE: state registers use non-blocking assignments so every flop samples
  // the pre-edge values regardless of process ordering.
  always_ff @(posedge clk_in or posedge rst_in) begin
    if (rst_in) begin
      state_q <= IDLE;
      owner_q <= OW'(NUM_REQ - 1);
      count_q <= '0;
      grant_q <= '0;
      busy_q  <= 1'b0;
      data_q  <= IDLE_PATTERN;
    end else begin
      state_q <= state_d;
      owner_q <= owner_d;
      count_q <= count_d;
      grant_q <= grant_d;
      busy_q  <= busy_d;
      data_q  <= data_d;
    end
  end

  assign grant_out = grant_q;
  assign owner_out = owner_q;
  assign busy_out  = busy_q;
  assign data_out  = data_q;

endmodule

// File: tb/tb_hex_display_arbiter.sv
// Self-checking bench for hex_display_arbiter: directed scenarios plus random
// stimulus against a held-cycle ownership model.
module tb_hex_display_arbiter;

  localparam int          N    = 4;
  localparam int          D    = 4;
  localparam logic [31:0] IDLE = 32'hDEAD_0000;

  logic          clk_in = 1'b0;
  logic          rst_in;
  logic [N-1:0]  req_in;
  logic [N*32-1:0] data_in;
  logic [N-1:0]  grant_out;
  logic [1:0]    owner_out;
  logic          busy_out;
  logic [31:0]   data_out;

  int errors = 0;
  int checks = 0;

  int          m_owner;
  bit          m_busy;
  int          m_held;
  logic [31:0] m_data;

  hex_display_arbiter #(
    .NUM_REQ      (N),
    .DWELL_CYCLES (D),
    .IDLE_PATTERN (IDLE)
  ) dut (
    .clk_in    (clk_in),
    .rst_in    (rst_in),
    .req_in    (req_in),
    .data_in   (data_in),
    .grant_out (grant_out),
    .owner_out (owner_out),
    .busy_out  (busy_out),
    .data_out  (data_out)
  );

  always #5 clk_in = ~clk_in;

  function automatic logic [31:0] word_of(int i);
    return data_in[32*i +: 32];
  endfunction

  function automatic logic [31:0] shown(int i, logic [31:0] w);
`ifdef HEX_ARB_SOURCE_TAG_EN
    logic [3:0] tag;
    tag = 4'(i);
    return {tag, w[27:0]};
`else
    return w;
`endif
  endfunction

  // Next requester after 'from' going upward with wrap; -1 when none.
  function automatic int rr_next(logic [N-1:0] req, int from, bit skip_self);
    for (int k = 1; k <= N; k++) begin
      int c = (from + k) % N;
      if (skip_self && c == from) continue;
      if (req[c]) return c;
    end
    return -1;
  endfunction

  function automatic logic [38:0] exp_vec();
    logic [N-1:0] g;
    logic [1:0]   o;
    g = m_busy ? (4'b0001 << m_owner) : 4'b0000;
    o = 2'(m_owner);
    return {g, o, m_busy, m_data};
  endfunction

  task automatic model_reset();
    m_owner = N - 1;
    m_busy  = 1'b0;
    m_held  = 0;
    m_data  = IDLE;
  endtask

  // m_held counts cycles the current owner has shown, starting at 1.
  task automatic model_step();
    int p;
    if (!m_busy) begin
      p = rr_next(req_in, m_owner, 1'b0);
      if (p >= 0) begin m_busy = 1'b1; m_owner = p; m_held = 1; end
    end else if (!req_in[m_owner]) begin
      p = rr_next(req_in, m_owner, 1'b0);
      if (p >= 0) begin m_owner = p; m_held = 1; end
      else m_busy = 1'b0;
    end else begin
      p = rr_next(req_in, m_owner, 1'b1);
      if (m_held >= D && p >= 0) begin m_owner = p; m_held = 1; end
      else if (m_held < D) m_held++;
    end
    m_data = m_busy ? shown(m_owner, word_of(m_owner)) : IDLE;
  endtask

  task automatic tick();
    model_step();
    @(posedge clk_in);
    #1;
  endtask

  task automatic do_reset();
    rst_in = 1'b1;
    req_in = '0;
    model_reset();
    repeat (2) @(posedge clk_in);
    #1;
    rst_in = 1'b0;
  endtask

  task automatic test_reset();
    rst_in  = 1'b1;
    req_in  = '0;
    data_in = {$urandom, $urandom, $urandom, $urandom};
    model_reset();
    #2;
    checks++;
    if ({grant_out, owner_out, busy_out, data_out} !== {4'b0000, 2'd3, 1'b0, IDLE}) begin
      errors++;
      $display("FAIL reset_state: got grant=%b owner=%0d busy=%b data=%h, want 0000/3/0/%h",
               grant_out, owner_out, busy_out, data_out, IDLE);
    end
    @(posedge clk_in); #1;
    rst_in = 1'b0;
    for (int i = 0; i < 10; i++) begin
      tick();
      checks++;
      if ({grant_out, busy_out, data_out} !== {4'b0000, 1'b0, IDLE}) begin
        errors++;
        $display("FAIL idle_cycle%0d: got grant=%b busy=%b data=%h, want 0000/0/%h",
                 i, grant_out, busy_out, data_out, IDLE);
      end
    end
  endtask

  task automatic test_single();
    logic [31:0] want;
    want = shown(2, 32'h1234_5678);
    do_reset();
    data_in[95:64] = 32'h1234_5678;
    req_in = 4'b0100;
    tick();
    checks++;
    if ({grant_out, owner_out, data_out} !== {4'b0100, 2'd2, want}) begin
      errors++;
      $display("FAIL single_grant: got grant=%b owner=%0d data=%h, want 0100/2/%h",
               grant_out, owner_out, data_out, want);
    end
    for (int i = 0; i < 22; i++) tick();
    checks++;
    if ({grant_out, owner_out, busy_out, data_out} !== exp_vec() || owner_out !== 2'd2) begin
      errors++;
      $display("FAIL single_hold: got grant=%b owner=%0d busy=%b data=%h, want %h",
               grant_out, owner_out, busy_out, data_out, exp_vec());
    end
  endtask

  task automatic test_contention();
    do_reset();
    data_in = {32'h3333_3333, 32'h2222_2222, 32'h1111_1111, 32'h0000_0000};
    req_in = 4'b1111;
    for (int i = 0; i < 20; i++) begin
      tick();
      checks++;
      if ({grant_out, owner_out, busy_out, data_out} !== exp_vec() ||
          owner_out !== 2'((i / D) % N) || !$onehot(grant_out)) begin
        errors++;
        $display("FAIL contention_cycle%0d: got grant=%b owner=%0d busy=%b data=%h, want owner %0d vec %h",
                 i, grant_out, owner_out, busy_out, data_out, (i / D) % N, exp_vec());
      end
    end
  endtask

  task automatic test_early_release();
    do_reset();
    req_in = 4'b0010;
    tick();
    tick();
    req_in = 4'b1000;
    tick();
    checks++;
    if (owner_out !== 2'd3 || grant_out !== 4'b1000 || {grant_out, owner_out, busy_out, data_out} !== exp_vec()) begin
      errors++;
      $display("FAIL early_handover: got grant=%b owner=%0d data=%h, want 1000/3/%h",
               grant_out, owner_out, data_out, m_data);
    end
    req_in = 4'b0000;
    tick();
    checks++;
    if ({grant_out, owner_out, busy_out, data_out} !== {4'b0000, 2'd3, 1'b0, IDLE}) begin
      errors++;
      $display("FAIL release_to_idle: got grant=%b owner=%0d busy=%b data=%h, want 0000/3/0/%h",
               grant_out, owner_out, busy_out, data_out, IDLE);
    end
  endtask

  task automatic test_simultaneous();
    do_reset();
    req_in = 4'b0001;
    repeat (4) tick();
    req_in = 4'b0100;
    tick();
    checks++;
    if (owner_out !== 2'd2 || grant_out !== 4'b0100) begin
      errors++;
      $display("FAIL simultaneous_handover: got grant=%b owner=%0d, want 0100/2", grant_out, owner_out);
    end
    req_in = 4'b0101;
    for (int i = 1; i <= D; i++) begin
      tick();
      checks++;
      if (owner_out !== ((i < D) ? 2'd2 : 2'd0) || {grant_out, owner_out, busy_out, data_out} !== exp_vec()) begin
        errors++;
        $display("FAIL reload_dwell%0d: got grant=%b owner=%0d data=%h, want %h",
                 i, grant_out, owner_out, data_out, exp_vec());
      end
    end
  endtask

  task automatic test_tag_and_async_reset();
    logic [31:0] want;
    want = shown(3, 32'hFFFF_FFFF);
    do_reset();
    data_in[127:96] = 32'hFFFF_FFFF;
    req_in = 4'b1000;
    tick();
    checks++;
    if (data_out !== want || owner_out !== 2'd3) begin
      errors++;
      $display("FAIL owner3_word: got owner=%0d data=%h, want 3/%h", owner_out, data_out, want);
    end
    tick();
    #3;
    rst_in = 1'b1;
    #1;
    checks++;
    if ({grant_out, busy_out, data_out} !== {4'b0000, 1'b0, IDLE}) begin
      errors++;
      $display("FAIL async_reset: got grant=%b busy=%b data=%h, want 0000/0/%h",
               grant_out, busy_out, data_out, IDLE);
    end
    model_reset();
    req_in = '0;
    @(posedge clk_in); #1;
    rst_in = 1'b0;
  endtask

  task automatic test_random();
    do_reset();
    for (int i = 0; i < 400; i++) begin
      if ($urandom_range(0, 3) == 0) req_in = N'($urandom);
      data_in = {$urandom, $urandom, $urandom, $urandom};
      tick();
      checks++;
      if ({grant_out, owner_out, busy_out, data_out} !== exp_vec() ||
          (busy_out && !$onehot(grant_out))) begin
        errors++;
        $display("FAIL random_cycle%0d: got grant=%b owner=%0d busy=%b data=%h, want %h",
                 i, grant_out, owner_out, busy_out, data_out, exp_vec());
      end
    end
  endtask

  initial begin
    test_reset();
    test_single();
    test_contention();
    test_early_release();
    test_simultaneous();
    test_tag_and_async_reset();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
